// File: rtl/bht_ctrl_if.sv
// Fetch/resolve handshake between the pipeline (master) and the branch-history-table controller (slave).
interface bht_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                fetch_valid;
  logic                fetch_is_branch;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                pred_take;
  logic                fetch_stall;
  logic                resolve_valid;
  logic                resolve_taken;
  logic                flush;
  logic                mispredict;
  logic                mispredict_taken;

  modport master (
    output fetch_valid, fetch_is_branch, fetch_pc, resolve_valid, resolve_taken, flush,
    input  pred_take, fetch_stall, mispredict, mispredict_taken
  );

  modport slave (
    input  fetch_valid, fetch_is_branch, fetch_pc, resolve_valid, resolve_taken, flush,
    output pred_take, fetch_stall, mispredict, mispredict_taken
  );
endinterface

// File: rtl/bht_ctrl.sv
// Branch-history-table controller: 2-bit counters, in-order in-flight FIFO, registered mispredict.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  bht_ctrl_if.slave                     bus,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          err_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]      FULL_CNT = OCC_W'(FIFO_DEPTH);
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic [INDEX_BITS-1:0] idx;
    logic                  pred;
  } fifo_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic                  ready_q, ready_d;
  logic                  mispredict_q, mispredict_d;
  logic                  mispredict_taken_q, mispredict_taken_d;
  logic                  err_q, err_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      count_q, count_d;

  logic [1:0]            table_q [2**INDEX_BITS];
  fifo_entry_t           fifo_q  [FIFO_DEPTH];

  logic [INDEX_BITS-1:0] lookup_idx;
  logic                  pred_take;
  fifo_entry_t           head;
  logic                  full, empty, running, branch_req, push, pop, clear;
  logic                  tbl_we, fifo_we;
  logic [INDEX_BITS-1:0] tbl_idx;
  logic [1:0]            tbl_data;

  // Only the index field of the PC feeds the table.
  logic pc_unused;
  assign pc_unused = ^{bus.fetch_pc[PC_WIDTH-1:INDEX_BITS+2], bus.fetch_pc[1:0]};

`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  assign lookup_idx = bus.fetch_pc[INDEX_BITS+1:2] ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (state_q == S_INIT) ghr_d = '0;
    else if (pop)          ghr_d = {ghr_q[INDEX_BITS-2:0], bus.resolve_taken};
  end

  always_ff @(posedge clock) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign lookup_idx = bus.fetch_pc[INDEX_BITS+1:2];
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    running    = (state_q == S_RUN);
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    head       = fifo_q[rd_ptr_q];
    pred_take  = ready_q & table_q[lookup_idx][1];
    branch_req = bus.fetch_valid & bus.fetch_is_branch;
    pop        = running & bus.resolve_valid & ~empty;
    // A pop frees the slot, so a full FIFO still accepts a same-cycle push.
    push       = running & branch_req & (~full | pop);
    mispredict_d       = pop & (head.pred != bus.resolve_taken);
    mispredict_taken_d = mispredict_d & bus.resolve_taken;
    // Entries younger than a mispredicted branch are wrong-path; drop them with the flush.
    clear      = mispredict_d | bus.flush;

    state_d  = state_q;
    sweep_d  = sweep_q;
    ready_d  = ready_q;
    tbl_we   = 1'b0;
    tbl_idx  = sweep_q;
    tbl_data = 2'b00;
    case (state_q)
      S_INIT: begin
        tbl_we  = 1'b1;
        sweep_d = sweep_q + INDEX_BITS'(1);
        if (sweep_q == LAST_IDX) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        if (pop) begin
          tbl_we   = 1'b1;
          tbl_idx  = head.idx;
          tbl_data = sat_update(table_q[head.idx], bus.resolve_taken);
        end
      end
      default: state_d = S_INIT;
    endcase

    fifo_we  = push & ~clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end

    err_d = err_q | (running & bus.resolve_valid & empty);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= S_INIT;
      sweep_q            <= '0;
      ready_q            <= 1'b0;
      mispredict_q       <= 1'b0;
      mispredict_taken_q <= 1'b0;
      err_q              <= 1'b0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
    end else begin
      state_q            <= state_d;
      sweep_q            <= sweep_d;
      ready_q            <= ready_d;
      mispredict_q       <= mispredict_d;
      mispredict_taken_q <= mispredict_taken_d;
      err_q              <= err_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; the INIT sweep clears the table and count_q masks stale FIFO slots.
  always_ff @(posedge clock) begin
    if (tbl_we)  table_q[tbl_idx]  <= tbl_data;
    if (fifo_we) fifo_q[wr_ptr_q] <= '{idx: lookup_idx, pred: pred_take};
  end

  assign bus.pred_take        = pred_take;
  assign bus.fetch_stall      = ~ready_q | (full & branch_req & ~bus.resolve_valid);
  assign bus.mispredict       = mispredict_q;
  assign bus.mispredict_taken = mispredict_taken_q;
  assign ready                = ready_q;
  assign occupancy            = count_q;
  assign err_underflow        = err_q;

endmodule

// File: doc/bht_ctrl.md
Name: bht_ctrl

Overview:
- Branch-history-table controller for the fetch/execute pipeline: owns an array of 2-bit saturating counters indexed by PC, provides same-cycle taken/not-taken predictions to fetch, and tracks in-flight predicted branches in an in-order FIFO.
- Retires each FIFO entry against the ALU branch outcome, updates the counter, and raises a registered mispredict pulse that squashes younger predictions.

Parameters:
- PC_WIDTH, 32, fetch/resolve PC width.
- INDEX_BITS, 6, table index width; table has 2^INDEX_BITS entries.
- FIFO_DEPTH, 4, maximum in-flight unresolved branches (power of 2, ≥2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch slot valid.
- fetch_is_branch  in  1  predecoded conditional branch in fetch slot.
- fetch_pc  in  PC_WIDTH  PC of fetch slot.
- pred_take  out  1  prediction for fetch_pc (combinational, counter MSB).
- fetch_stall  out  1  fetch must hold: !ready, or FIFO full with fetch_valid&&fetch_is_branch.
- resolve_valid  in  1  oldest in-flight branch resolved this cycle.
- resolve_taken  in  1  actual outcome from ALU.
- flush  in  1  external pipeline flush; discards all in-flight entries.
- mispredict  out  1  registered one-cycle pulse: resolved outcome ≠ stored prediction.
- mispredict_taken  out  1  actual outcome of the mispredicted branch, valid with mispredict.
- ready  out  1  table initialisation complete.
- occupancy  out  clog2(FIFO_DEPTH)+1  in-flight entry count.
- err_underflow  out  1  sticky: resolve_valid seen with empty FIFO.

Behaviour:
- States: INIT, RUN. Reset → INIT, sweep pointer 0. INIT writes 2'b00 (strong not-taken) to one entry per cycle, 2^INDEX_BITS cycles. After the last write → RUN, ready=1 on the following cycle.
- Reset values: ready=0, mispredict=0, mispredict_taken=0, occupancy=0, err_underflow=0, FIFO pointers 0.
- In INIT: fetch_stall=1, pushes and resolves ignored, err_underflow not set. Reset mid-operation restarts INIT from entry 0.
- Index = fetch_pc[INDEX_BITS+1:2]. pred_take = MSB of the indexed counter, combinational, valid whenever ready.
- Push when fetch_valid && fetch_is_branch && ready && not full. Entry = {index, pred_take}.
- Pop when resolve_valid && not empty.
- Counter update on pop, at the stored index, written at the clock edge:
  - taken: 00→01→10→11, saturating at 11.
  - not-taken: 11→10→01→00, saturating at 00.
- Same-cycle update and lookup of the same index: lookup returns the pre-update value. No bypass.
- Mispredict: popped prediction ≠ resolve_taken → mispredict=1 and mispredict_taken=resolve_taken on the next cycle (1-cycle latency). The FIFO is emptied at that edge (younger entries are wrong-path), and any same-cycle push is dropped.
- flush: empties the FIFO at the edge, overriding any push. A same-cycle pop still updates its counter and may still raise mispredict.
- Simultaneous push and pop while full: both take effect, occupancy unchanged. fetch_stall is not asserted in this case only when resolve_valid is also high (pop frees the slot).
- Resolve with empty FIFO: no pop, no update, no mispredict, err_underflow←1 until reset.
- Pointers wrap modulo FIFO_DEPTH. occupancy ranges 0..FIFO_DEPTH.

Optional Feature:
- BHT_GSHARE_EN defined:
  - Adds a global history register, INDEX_BITS wide, reset to 0, cleared during INIT.
  - index = fetch_pc[INDEX_BITS+1:2] XOR ghr.
  - On each pop: ghr ← {ghr[INDEX_BITS-2:0], resolve_taken}.
  - Updates use the stored index, not a recomputed one.
  - On mispredict or flush, ghr keeps its post-pop value.
- Not defined: pure PC indexing, no ghr logic.

Test Plan:
- Reset, then idle → ready rises after exactly 64 cycles (default). pred_take=0 for any PC. fetch_stall=1 throughout INIT.
- Branch at pc=0x40 resolved taken three times → pred_take=0, 0, 1, 1 on successive lookups. mispredict pulses on resolves 1 and 2 only, with mispredict_taken=1.
- Push 4 branches with no resolve → occupancy=4 and fetch_stall=1 on the 5th branch. Push+resolve in the same cycle → push accepted, occupancy stays 4.
- 3 in flight, oldest resolves opposite to its prediction → mispredict=1 next cycle, occupancy=0, same-cycle push dropped.
- resolve_valid with empty FIFO → err_underflow=1, holds after later valid traffic, table unchanged.
- Assert reset mid-run with 2 in flight → ready=0, occupancy=0, all counters re-cleared to 00 after a full INIT sweep.
